bcd_ascii_serializer: RTL and testbench
=======================================

BCD_ASCII_SERIALIZER -- requirements
Module: bcd_ascii_serializer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per input word (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: input word offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-006 SHALL have port in_bcd, input, 4*DIGITS bits: packed BCD word, most significant digit in the top nibble.
REQ-007 SHALL have port out_valid, output, 1 bit: out_char is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: sink accepts out_char.
REQ-009 SHALL have port out_char, output, 8 bits: ASCII character.
REQ-010 SHALL have port out_last, output, 1 bit: current character is the final character of the word.
REQ-011 SHALL have port out_err, output, 1 bit: current digit was not valid BCD (value above 9).

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SEND.
REQ-013 in_ready SHALL be 1 exactly when the FSM is in IDLE.
REQ-014 An accept SHALL occur when in_valid and in_ready are both 1 on a clock edge; on accept, the block SHALL capture in_bcd and enter SEND.
REQ-015 out_valid SHALL be 1 exactly when the FSM is in SEND, so the first character appears 1 cycle after accept.
REQ-016 Characters SHALL be emitted most significant digit first, one per out_valid&out_ready handshake.
REQ-017 For digits 0..9, out_char SHALL be {4'h3, digit} and out_err SHALL be 0.
REQ-018 For digits 10..15, out_char SHALL be 8'h3F ('?') and out_err SHALL be 1.
REQ-019 out_last SHALL be 1 only while the least significant digit is presented.
REQ-020 A handshake on the out_last character SHALL return the FSM to IDLE; word period is therefore (emitted characters + 1) cycles with out_ready held 1.
REQ-021 While out_valid=1 and out_ready=0, out_char, out_last and out_err SHALL hold stable.
REQ-022 Changes on in_bcd and in_valid during SEND SHALL have no effect on the output.
REQ-023 out_char, out_last and out_err SHALL be registered outputs.
REQ-024 With DIGITS=1, the single character SHALL carry out_last=1.

Reset
REQ-025 While rst_n=0, the block SHALL force FSM=IDLE, out_valid=0, out_char=8'h00, out_last=0, out_err=0 and in_ready=1, independent of clk.
REQ-026 Asserting reset mid-word SHALL discard the captured word, with no further characters from it after reset release.
REQ-027 The first accept SHALL be possible on the first clock edge after rst_n deasserts.

Configuration
REQ-028 With macro BCD_LZ_SUPPRESS_EN defined, the block SHALL skip leading zero digits on accept, starting emission at the most significant nonzero digit. An invalid digit counts as nonzero. The least significant digit is always emitted.
REQ-029 Without BCD_LZ_SUPPRESS_EN, all DIGITS characters SHALL be emitted and no leading-zero search logic SHALL be synthesised.

Verification (DIGITS=4)
REQ-030 Basic: in_bcd=16'h1234 with out_ready=1 -> 8'h31, 8'h32, 8'h33, 8'h34 on 4 consecutive cycles starting 1 cycle after accept. out_last=1 only with 8'h34. in_ready=0 for those 4 cycles, then 1.
REQ-031 Backpressure: out_ready=0 for 3 cycles while 8'h32 is shown -> 8'h32 held stable, then sequence resumes with 8'h33 and 8'h34, no loss or duplication.
REQ-032 Invalid digit: in_bcd=16'h12A4 -> 8'h31, 8'h32, 8'h3F, 8'h34. out_err=1 only on 8'h3F.
REQ-033 Zero suppression: 16'h0045 -> 8'h34, 8'h35 with the macro, and 8'h30, 8'h30, 8'h34, 8'h35 without it. 16'h0000 with the macro -> single 8'h30 with out_last=1.
REQ-034 Reset mid-word: rst_n low after 2 characters of 16'h1234 -> out_valid drops to 0 immediately and in_ready=1. After release, 16'h9876 -> 8'h39, 8'h38, 8'h37, 8'h36 only.
REQ-035 Busy hold-off: in_valid held 1 with a second word 16'h5555 during SEND -> second word not accepted until the cycle after the out_last handshake, then emitted intact.

Source files
------------

// File: rtl/bcd_ascii_serializer.sv
// Packed BCD word to ASCII character stream, most significant digit first.
// Optional leading-zero suppression is enabled by defining BCD_LZ_SUPPRESS_EN.
module bcd_ascii_serializer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_char,
    output logic                  out_last,
    output logic                  out_err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [IW-1:0] start;
    logic          accept;
    logic          fire;

    // Returns {err, char} for one BCD digit.
    function automatic logic [8:0] enc(input logic [3:0] d);
        if (d > 4'd9) begin
            return {1'b1, 8'h3F};
        end
        return {1'b0, 4'h3, d};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign nidx      = idx - 1'b1;

`ifdef BCD_LZ_SUPPRESS_EN
    // Highest nonzero digit position; the last digit is the floor.
    always_comb begin
        start = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (in_bcd[4*i +: 4] != 4'h0) begin
                start = IW'(i);
            end
        end
    end
`else
    assign start = IW'(DIGITS - 1);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture on accept, return after the last handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (fire && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture, digit pointer and registered character outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            idx      <= '0;
            out_char <= 8'h00;
            out_last <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            word                <= in_bcd;
            idx                 <= start;
            {out_err, out_char} <= enc(in_bcd[4*start +: 4]);
            out_last            <= (start == '0);
        end else if (fire && !out_last) begin
            idx                 <= nidx;
            {out_err, out_char} <= enc(word[4*nidx +: 4]);
            out_last            <= (nidx == '0);
        end
    end

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Scoreboard bench for bcd_ascii_serializer (DIGITS=4).
// Directed spec cases plus random words with random sink backpressure.
module tb_bcd_ascii_serializer;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*D-1:0] in_bcd = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [7:0]     out_char;
    logic           out_last;
    logic           out_err;

    int tests = 0;
    int fails = 0;

    // Expected entries: {err, last, char}
    logic [9:0] sb[$];
    bit         rand_ready = 1'b0;
    int         popped = 0;

    bcd_ascii_serializer #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: list of characters a word should produce.
    task automatic push_word(input logic [4*D-1:0] w);
        int top;
        int d;
        top = D - 1;
`ifdef BCD_LZ_SUPPRESS_EN
        while (top > 0 && ((w >> (4 * top)) & 15) == 0) top--;
`endif
        for (int k = top; k >= 0; k--) begin
            d = int'((w >> (4 * k)) & 15);
            if (d > 9) sb.push_back({1'b1, k == 0, 8'h3F});
            else       sb.push_back({1'b0, k == 0, 8'(48 + d)});
        end
    endtask

    // Offer a word until accepted; in_valid stays high while busy.
    task automatic send_word(input logic [4*D-1:0] w);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_bcd   = w;
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        push_word(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        check("first_valid", out_valid, 1);
        check("busy_ready", in_ready, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
    endtask

    // Random sink backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop on handshake, check stability while stalled.
    logic [9:0] held;
    bit         stalled = 1'b0;
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            check("ready_vs_valid", in_ready, !out_valid);
            if (stalled && out_valid)
                check("hold_stable", {out_err, out_last, out_char}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_char", out_char, 8'hxx);
                end else begin
                    e = sb.pop_front();
                    check("char", out_char, e[7:0]);
                    check("last", out_last, e[8]);
                    check("err", out_err, e[9]);
                    popped++;
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = {out_err, out_last, out_char};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [4*D-1:0] w;
        int             n;
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_char", out_char, 8'h00);
        check("rst_last", out_last, 0);
        check("rst_err", out_err, 0);
        @(posedge clk); #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        send_word(16'h1234);
        drain();
        send_word(16'h12A4);
        drain();
        send_word(16'h0045);
        drain();
        send_word(16'h0000);
        drain();

        // Backpressure while '2' is shown.
        send_word(16'h1234);
        @(posedge clk); #1;
        check("bp_char", out_char, 8'h32);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold", out_char, 8'h32);
        out_ready = 1'b1;
        drain();

        // Busy hold-off: second word offered during SEND.
        send_word(16'h1234);
        send_word(16'h5555);
        drain();

        // Reset mid-word after two characters.
        popped = 0;
        send_word(16'h1234);
        n = 0;
        while (popped < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("two_popped", popped, 2);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_char", out_char, 8'h00);
        @(posedge clk); #3;
        rst_n = 1'b1;
        send_word(16'h9876);
        drain();

        // Random words with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:8] = 8'h00;
            if ($urandom_range(0, 4) == 0) w[7:4] = 4'h0;
            send_word(w);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
